// File: rtl/delay_line_ram.sv
// Circular-buffer delay line on a single-clock dual-port RAM.
// Each sample strobe writes one sample and returns the one written `offset`
// strobes earlier. Output data stays at zero until the buffer has seen
// enough samples to supply real data. In freeze mode the stored contents
// replay with a period of 2**ADDRESS_WIDTH strobes.
module delay_line_ram #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     freeze,
  input  logic [ADDRESS_WIDTH-1:0] offset,
  input  logic [DATA_WIDTH-1:0]    din,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     dout_valid,
  output logic                     dout_primed
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  // Sample storage; contents are deliberately not reset. Stale data left
  // over after a reset is hidden by the fill count starting again at zero.
  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  logic [ADDRESS_WIDTH-1:0] wr_ptr_reg;
  logic [ADDRESS_WIDTH:0]   fill_reg;
  logic [ADDRESS_WIDTH:0]   fill_next;
  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic                     mask;
  logic                     accept;

  logic [DATA_WIDTH-1:0]    rd_data_reg;
  logic [DATA_WIDTH-1:0]    bypass_reg;
  logic                     bypass_sel_reg;
  logic                     primed_reg;
  logic                     valid_reg;

  // Reset wins over a simultaneous strobe, so the sample is dropped.
  assign accept = en && !rst;

  // Read address, saturating fill count and output mask for this strobe.
  always_comb begin
    rd_addr   = wr_ptr_reg - offset;
    fill_next = fill_reg[ADDRESS_WIDTH] ? fill_reg : fill_reg + 1'b1;
    if (freeze) begin
      // Replay is only meaningful once every location has been written.
      mask = !fill_reg[ADDRESS_WIDTH];
    end else begin
      mask = (fill_reg < {1'b0, offset});
    end
  end

  // RAM write port; freeze inhibits writes so the buffer loops.
  always_ff @(posedge clk) begin
    if (accept && !freeze) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // RAM synchronous read port; returns old contents when it overlaps a write.
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  // Pointer, fill count and output-select registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      fill_reg       <= '0;
      valid_reg      <= 1'b0;
      primed_reg     <= 1'b0;
      bypass_sel_reg <= 1'b0;
      bypass_reg     <= '0;
    end else begin
      valid_reg <= en;
      if (en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (!freeze) begin
          fill_reg <= fill_next;
        end
        primed_reg <= !mask;
        // Zero delay in normal mode bypasses the RAM; in freeze mode offset 0
        // reads the slot about to be revisited, giving a full-period replay.
        bypass_sel_reg <= !freeze && (offset == '0);
        bypass_reg     <= din;
      end
    end
  end

  // Output select from registered state only; masked output is forced to zero.
  always_comb begin
    if (!primed_reg) begin
      dout = '0;
    end else if (bypass_sel_reg) begin
      dout = bypass_reg;
    end else begin
      dout = rd_data_reg;
    end
  end

  assign dout_valid  = valid_reg;
  assign dout_primed = primed_reg;

endmodule

// File: tb/tb_delay_line_ram.sv
// Scoreboard bench for delay_line_ram with a 16-entry buffer.
// The driver pushes hand-computed expectations per strobe; a monitor on the
// falling edge pops and compares whenever dout_valid is high, checks the
// reset state and checks that outputs hold between strobes.
module tb_delay_line_ram;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          freeze = 1'b0;
  logic [AW-1:0] offset = '0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_primed;

  int checks = 0;
  int errors = 0;

  logic [DW:0] exp_q [$];   // {primed, data}

  delay_line_ram #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .freeze(freeze), .offset(offset),
    .din(din), .dout(dout), .dout_valid(dout_valid), .dout_primed(dout_primed)
  );

  always #5 clk = ~clk;

  // Monitor: inputs change 1 ns after posedge, so the value seen at a falling
  // edge is the one the next rising edge samples; remember it for one cycle.
  logic          rst_last = 1'b1;
  logic          en_last = 1'b0;
  logic [DW-1:0] hold_d = '0;
  logic          hold_p = 1'b0;
  always @(negedge clk) begin
    logic [DW:0] e;
    if (rst_last) begin
      checks++;
      if (dout !== '0 || dout_valid !== 1'b0 || dout_primed !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: got dout=%0d valid=%0b primed=%0b, need 0/0/0",
                 dout, dout_valid, dout_primed);
      end
      hold_d = '0;
      hold_p = 1'b0;
    end else if (dout_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got dout=%0d with no strobe pending", dout);
      end else begin
        e = exp_q.pop_front();
        if (dout !== e[DW-1:0] || dout_primed !== e[DW]) begin
          errors++;
          $display("FAIL sample: got dout=%0d primed=%0b, need dout=%0d primed=%0b",
                   dout, dout_primed, e[DW-1:0], e[DW]);
        end
        hold_d = e[DW-1:0];
        hold_p = e[DW];
      end
    end else begin
      checks++;
      if (en_last) begin
        errors++;
        $display("FAIL missing_valid: got dout_valid=%0b after strobe, need 1", dout_valid);
      end else if (dout !== hold_d || dout_primed !== hold_p) begin
        errors++;
        $display("FAIL hold: got dout=%0d primed=%0b, need dout=%0d primed=%0b",
                 dout, dout_primed, hold_d, hold_p);
      end
    end
    rst_last = rst;
    en_last  = en;
  end

  task automatic strobe(input logic [AW-1:0] off, input logic [DW-1:0] d,
                        input logic frz, input logic [DW-1:0] ed, input logic ep);
    @(posedge clk) #1;
    rst = 1'b0; en = 1'b1; offset = off; din = d; freeze = frz;
    exp_q.push_back({ep, ed});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk) #1;
      rst = 1'b0; en = 1'b0; freeze = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk) #1;
    rst = 1'b1; en = 1'b0; freeze = 1'b0;
    @(posedge clk) #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: offset 3, din 1..8 -> 0,0,0,1,2,3,4,5
    do_reset();
    for (int i = 1; i <= 8; i++)
      strobe(3, DW'(i), 1'b0, (i <= 3) ? '0 : DW'(i - 3), (i > 3));
    idle(2);

    // 2: zero-delay bypass
    do_reset();
    strobe(0, 8'h55, 1'b0, 8'h55, 1'b1);
    idle(2);

    // 3: max delay 15 across pointer wraps at 16 and 32
    do_reset();
    for (int k = 0; k < 40; k++)
      strobe(15, DW'(k), 1'b0, (k < 15) ? '0 : DW'(k - 15), (k >= 15));
    idle(2);

    // 4: sparse strobes, offset 1; outputs hold between strobes
    do_reset();
    strobe(1, 10, 1'b0, 0, 1'b0);  idle(2);
    strobe(1, 20, 1'b0, 10, 1'b1); idle(2);
    strobe(1, 30, 1'b0, 20, 1'b1); idle(3);

    // 5: fill 16 entries then freeze-replay with offset 0 for 20 strobes
    do_reset();
    for (int k = 0; k < 16; k++)
      strobe(0, DW'(k), 1'b0, DW'(k), 1'b1);
    for (int j = 0; j < 20; j++)
      strobe(0, 8'hAA, 1'b1, DW'(j % 16), 1'b1);
    idle(2);

    // 5b: freeze before the buffer has ever been filled stays masked
    do_reset();
    for (int k = 0; k < 3; k++)
      strobe(0, DW'(k + 1), 1'b0, DW'(k + 1), 1'b1);
    strobe(0, 8'hAA, 1'b1, 0, 1'b0);
    idle(2);

    // 6: mid-stream reset masks stale memory
    do_reset();
    for (int k = 0; k < 10; k++)
      strobe(2, DW'(k + 1), 1'b0, (k < 2) ? '0 : DW'(k - 1), (k >= 2));
    do_reset();
    strobe(2, 100, 1'b0, 0, 1'b0);
    strobe(2, 101, 1'b0, 0, 1'b0);
    strobe(2, 102, 1'b0, 100, 1'b1);
    idle(2);

    // 7: reset together with a strobe drops that sample
    @(posedge clk) #1;
    rst = 1'b1; en = 1'b1; din = 77; offset = 1; freeze = 1'b0;
    strobe(1, 5, 1'b0, 0, 1'b0);
    strobe(1, 6, 1'b0, 5, 1'b1);
    // Offset raised beyond fill: masked until fill catches up
    strobe(4, 7, 1'b0, 0, 1'b0);
    strobe(4, 8, 1'b0, 0, 1'b0);
    strobe(4, 9, 1'b0, 5, 1'b1);
    idle(2);

    // Drain with a bounded wait
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outputs outstanding, need 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
